// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, flag bundle and state encoding for alu_pipe
// Contents:
//   alu_op_e    - the eight 3-bit function codes
//   alu_flags_t - packed {zero, neg, carry, ovf}
//   alu_state_e - IDLE / MUL sequencing states
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_ADD = 3'd2,
        OP_MUL = 3'd3,
        OP_SLL = 3'd4,
        OP_SRL = 3'd5,
        OP_SUB = 3'd6,
        OP_SLT = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
    } alu_flags_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, low WIDTH bits of the unsigned product
// Ports:
//   clk, rst_n    - clock, async active-low reset
//   start         - load operands a/b and begin WIDTH steps
//   a, b          - operands (sampled on start)
//   done          - high in the cycle whose edge performs the final step
//   p             - product, valid while done is high
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] p
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, mc, mp, step;

    // p is the accumulator after the current step, so the final step's result
    // can be captured by the caller on the same edge it is produced
    assign step = acc + (mp[0] ? mc : '0);
    assign done = busy && cnt == CW'(1);
    assign p    = step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
            acc  <= '0;
            mc   <= '0;
            mp   <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CW'(WIDTH);
            acc  <= '0;
            mc   <= a;
            mp   <= b;
        end else if (busy) begin
            acc  <= step;
            mc   <= mc << 1;
            mp   <= mp >> 1;
            cnt  <= cnt - CW'(1);
            busy <= cnt != CW'(1);
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered, valid/ready handshaked ALU with status flags and optional iterative multiply
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   in_valid / in_ready   - operation handshake (a, b, f)
//   a, b, f               - operands and 3-bit function code
//   out_valid / out_ready - result handshake
//   y                     - registered result
//   zero, neg, carry, ovf - registered status flags for y
// Macro ALU_PIPE_MUL_EN: compiles in the MUL state and alu_mul_seq; otherwise f=3 returns 0 in one cycle.
module alu_pipe
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf
);
    logic             accept, load, idle, sub_op, addsub;
    logic             mul_done;
    logic [WIDTH-1:0] mul_p, res, y_nx;
    logic [WIDTH:0]   sum;
    alu_flags_t       flg, flg_nx;

    assign in_ready = rst_n && idle && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
    alu_state_e state, state_nx;
    logic       mul_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        mul_start = 1'b0;
        if (state == IDLE && accept && f == OP_MUL) begin
            state_nx  = MUL;
            mul_start = 1'b1;
        end else if (state == MUL && mul_done) begin
            state_nx = IDLE;
        end
    end

    assign idle = state == IDLE;
    assign load = (accept && f != OP_MUL) || mul_done;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (a),
        .b     (b),
        .done  (mul_done),
        .p     (mul_p)
    );
`else
    assign idle     = 1'b1;
    assign load     = accept;
    assign mul_done = 1'b0;
    assign mul_p    = '0;
`endif

    // SUB reuses the adder as a + ~b + 1; carry-out is then "not borrow"
    assign sub_op = f == OP_SUB;
    assign sum    = {1'b0, a} + {1'b0, sub_op ? ~b : b} + {{WIDTH{1'b0}}, sub_op};

    always_comb begin
        res = '0;
        case (alu_op_e'(f))
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_ADD:  res = sum[WIDTH-1:0];
            OP_SLL:  res = a << b[SHW-1:0];
            OP_SRL:  res = a >> b[SHW-1:0];
            OP_SUB:  res = sum[WIDTH-1:0];
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            default: res = '0;
        endcase
    end

    // f is don't-care while a multiply completes, so gate add/sub flags on !mul_done
    assign y_nx   = mul_done ? mul_p : res;
    assign addsub = !mul_done && (f == OP_ADD || f == OP_SUB);

    always_comb begin
        flg_nx       = '0;
        flg_nx.zero  = y_nx == '0;
        flg_nx.neg   = y_nx[WIDTH-1];
        flg_nx.carry = addsub && sum[WIDTH];
        // overflow when both effective addends share a sign the result lacks
        flg_nx.ovf   = addsub && (a[WIDTH-1] == (b[WIDTH-1] ^ sub_op)) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            flg       <= '0;
        end else begin
            out_valid <= load || (out_valid && !out_ready);
            if (load) begin
                y   <= y_nx;
                flg <= flg_nx;
            end
        end
    end

    assign zero  = flg.zero;
    assign neg   = flg.neg;
    assign carry = flg.carry;
    assign ovf   = flg.ovf;

endmodule
